// File: rtl/carryless_divider.sv
// Sequential GF(2) polynomial divider: one dividend bit per cycle, MSB first.
// Optional macro CARRYLESS_DIVIDER_ZERO_SKIP_EN: a zero divisor completes straight after accept.
`timescale 1ns/1ps
module carryless_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  data_valid_o,
  output logic                  idle_o,
  output logic                  divide_by_zero_o
);

  localparam int DEG_W = $clog2(DATA_WIDTH);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   dvd_q, dvs_q, rem_q, quo_q;
  logic [DATA_WIDTH-1:0]   quotient_q, remainder_q;
  logic [DEG_W-1:0]        deg_q;
  logic                    zero_q;
  logic                    accept, zero_in, last_iter, hit;
  logic [DATA_WIDTH-1:0]   rem_nxt, quo_nxt;

  function automatic logic [DEG_W-1:0] lead_one(input logic [DATA_WIDTH-1:0] v);
    lead_one = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (v[i]) lead_one = DEG_W'(i);
    end
  endfunction

  // The partial remainder always stays below the divisor degree, so shifting
  // in one bit can never reach past bit DATA_WIDTH-1.
  function automatic logic [DATA_WIDTH:0] clmod_step(
    input logic [DATA_WIDTH-1:0] rem,
    input logic                  din,
    input logic [DATA_WIDTH-1:0] dvs,
    input logic [DEG_W-1:0]      deg,
    input logic                  zero
  );
    logic [DATA_WIDTH-1:0] shifted;
    logic                  h;
    shifted = (rem << 1) | DATA_WIDTH'(din);
    h       = !zero && shifted[deg];
    return {h, h ? (shifted ^ dvs) : shifted};
  endfunction

  assign accept    = (state_q == S_IDLE) && data_valid_i;
  assign zero_in   = (divisor_i == '0);
  assign last_iter = (cnt_q == LAST_ITER);
  assign {hit, rem_nxt} = clmod_step(rem_q, dvd_q[DATA_WIDTH-1], dvs_q, deg_q, zero_q);
  assign quo_nxt   = (quo_q << 1) | DATA_WIDTH'(hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_valid_i) begin
`ifdef CARRYLESS_DIVIDER_ZERO_SKIP_EN
          state_d = zero_in ? S_DONE : S_DIVIDE;
`else
          state_d = S_DIVIDE;
`endif
        end
      end
      S_DIVIDE: if (last_iter) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle_o           = (state_q == S_IDLE);
    data_valid_o     = (state_q == S_DONE);
    divide_by_zero_o = (state_q == S_DONE) && zero_q;
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

  // Iteration counter and result registers; results only change on entry to DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      if (accept) cnt_q <= '0;
      else if (state_q == S_DIVIDE) cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
      if (state_q == S_DIVIDE && last_iter) begin
        quotient_q  <= zero_q ? '1 : quo_nxt;
        remainder_q <= rem_nxt;
      end
`ifdef CARRYLESS_DIVIDER_ZERO_SKIP_EN
      if (accept && zero_in) begin
        quotient_q  <= '1;
        remainder_q <= dividend_i;
      end
`endif
    end
  end

  // Working datapath; with no XOR on a zero divisor the remainder collects the dividend.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      dvd_q  <= dividend_i;
      dvs_q  <= divisor_i;
      deg_q  <= lead_one(divisor_i);
      zero_q <= zero_in;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (state_q == S_DIVIDE) begin
      dvd_q <= dvd_q << 1;
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_carryless_divider.sv
// Scoreboard bench for carryless_divider at DATA_WIDTH = 8.
`timescale 1ns/1ps
module tb_carryless_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         data_valid_i = 1'b0;
  logic [W-1:0] dividend_i = '0;
  logic [W-1:0] divisor_i = '0;
  logic [W-1:0] quotient_o, remainder_o;
  logic         data_valid_o, idle_o, divide_by_zero_o;

  always #5 clk = ~clk;

  carryless_divider #(.DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_valid_i(data_valid_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .data_valid_o(data_valid_o), .idle_o(idle_o),
    .divide_by_zero_o(divide_by_zero_o)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   edge_n = 0;
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;

  always @(posedge clk) edge_n++;

  // Reference: classic long division by the divisor's leading term.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    int d;
    d = -1;
    for (int i = 0; i < W; i++) if (b[i]) d = i;
    if (d < 0) begin
      q = '1;
      r = a;
      return;
    end
    q = '0;
    r = a;
    for (int i = W - 1; i >= d; i--) begin
      if (r[i]) begin
        r = r ^ (b << (i - d));
        q[i-d] = 1'b1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (data_valid_o === 1'b1) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse at edge %0d got q=%h r=%h, no result was due", edge_n, quotient_o, remainder_o);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (quotient_o !== mon_e.q) begin
          failures++;
          $display("FAIL quotient got=%h exp=%h", quotient_o, mon_e.q);
        end
        checks++;
        if (remainder_o !== mon_e.r) begin
          failures++;
          $display("FAIL remainder got=%h exp=%h", remainder_o, mon_e.r);
        end
        checks++;
        if (divide_by_zero_o !== mon_e.dbz) begin
          failures++;
          $display("FAIL divide_by_zero got=%b exp=%b", divide_by_zero_o, mon_e.dbz);
        end
        checks++;
        if (edge_n - mon_e.acc !== mon_e.lat) begin
          failures++;
          $display("FAIL latency got cycle %0d exp cycle %0d", edge_n - mon_e.acc + 1, mon_e.lat + 1);
        end
      end
    end
  end

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                          input logic [W-1:0] eq, input logic [W-1:0] er, output int acc);
    exp_t e;
    int   n;
    n = 0;
    @(posedge clk); #1;
    while (idle_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    dividend_i   = a;
    divisor_i    = b;
    data_valid_i = 1'b1;
    acc = edge_n + 1;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = (b == '0); e.acc = acc; e.lat = W;
`ifdef CARRYLESS_DIVIDER_ZERO_SKIP_EN
      if (b == '0) e.lat = 0;
`endif
      sb.push_back(e);
    end
    @(posedge clk); #1;
    data_valid_i = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (idle_o !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle_o); end
    checks++; if (data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid_o); end
    checks++; if (quotient_o !== '0) begin failures++; $display("FAIL reset_quotient got=%h exp=00", quotient_o); end
    checks++; if (remainder_o !== '0) begin failures++; $display("FAIL reset_remainder got=%h exp=00", remainder_o); end
    checks++; if (divide_by_zero_o !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", divide_by_zero_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{8'h21, 8'h27, 8'hA5, 8'h03, 8'h80, 8'hFF, 8'h5A};
    logic [W-1:0] tb [7] = '{8'h0B, 8'h0B, 8'h01, 8'h0B, 8'h80, 8'h80, 8'h00};
    logic [W-1:0] tq [7] = '{8'h05, 8'h05, 8'hA5, 8'h00, 8'h01, 8'h01, 8'hFF};
    logic [W-1:0] tr [7] = '{8'h06, 8'h00, 8'h00, 8'h03, 8'h00, 8'h7F, 8'h5A};
    int acc;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      drive_op(ta[i], tb[i], 1'b1, tq[i], tr[i], acc);
      @(negedge clk);
      checks++; if (idle_o !== 1'b0) begin failures++; $display("FAIL busy_idle op%0d got=%b exp=0", i, idle_o); end
      wait_drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL timeout op%0d got=no result exp=result", i); end
      @(negedge clk);
      checks++; if (idle_o !== 1'b1) begin failures++; $display("FAIL idle_after op%0d got=%b exp=1", i, idle_o); end
      repeat (3) @(negedge clk);
      checks++;
      if (quotient_o !== tq[i] || remainder_o !== tr[i]) begin
        failures++;
        $display("FAIL hold op%0d got q=%h r=%h exp q=%h r=%h", i, quotient_o, remainder_o, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r;
    int acc;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = (i % 4 == 0) ? W'($urandom_range(1, 7)) : W'($urandom);
      model(a, b, q, r);
      drive_op(a, b, 1'b1, q, r, acc);
      wait_drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL timeout rand%0d got=no result exp=result", i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, q, r;
    exp_t e;
    int accepts, p0;
    bit ok;
    accepts = 0;
    p0 = pulses;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      dividend_i   = a;
      divisor_i    = b;
      data_valid_i = 1'b1;
      if (idle_o === 1'b1) begin
        model(a, b, q, r);
        e.q = q; e.r = r; e.dbz = (b == '0); e.acc = edge_n + 1; e.lat = W;
`ifdef CARRYLESS_DIVIDER_ZERO_SKIP_EN
        if (b == '0) e.lat = 0;
`endif
        sb.push_back(e);
        accepts++;
      end
    end
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout b2b got=no result exp=result"); end
    checks++; if (pulses - p0 !== accepts) begin failures++; $display("FAIL b2b_pulses got=%0d exp=%0d", pulses - p0, accepts); end
    checks++; if (accepts < 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp>=4", accepts); end
  endtask

  task automatic test_reset_abort();
    int acc, p0;
    bit ok;
    p0 = pulses;
    drive_op(8'h21, 8'h0B, 1'b0, '0, '0, acc);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checks++; if (idle_o !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", idle_o); end
    checks++; if (data_valid_o !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", data_valid_o); end
    checks++; if (quotient_o !== '0) begin failures++; $display("FAIL abort_quotient got=%h exp=00", quotient_o); end
    checks++; if (remainder_o !== '0) begin failures++; $display("FAIL abort_remainder got=%h exp=00", remainder_o); end
    checks++; if (divide_by_zero_o !== 1'b0) begin failures++; $display("FAIL abort_dbz got=%b exp=0", divide_by_zero_o); end
    repeat (12) @(negedge clk);
    checks++; if (pulses !== p0) begin failures++; $display("FAIL abort_pulse got=%0d pulses exp=0", pulses - p0); end
    drive_op(8'h27, 8'h0B, 1'b1, 8'h05, 8'h00, acc);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout after_abort got=no result exp=result"); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
